spike_packet_receiver: RTL and testbench

SPIKE_PACKET_RECEIVER -- requirements
Module: spike_packet_receiver

---
 rtl/spike_packet_receiver_pkg.sv | 18 +
 rtl/spike_addr_fifo.sv | 66 ++++++
 rtl/spike_packet_receiver.sv | 147 ++++++++++++++
 tb/tb_spike_packet_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_packet_receiver_pkg.sv
// rtl/spike_packet_receiver_pkg.sv - shared widths, defaults and FSM encoding for the spike receiver
// Purpose: constants shared by spike_packet_receiver and spike_addr_fifo.
// Ports: none (package).
package spike_packet_receiver_pkg;

   localparam int ADDR_W              = 12;
   localparam int WEIGHT_W            = 32;
   localparam int SLOT_IDX_W          = 5;
   localparam int NEURON_W            = 4;

   localparam int DEF_NUM_NEURONS     = 10;
   localparam int DEF_CONN_PER_NEURON = 3;
   localparam int DEF_FIFO_DEPTH      = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

endpackage

// File: rtl/spike_addr_fifo.sv
// rtl/spike_addr_fifo.sv - synchronous packet-address FIFO with full/empty flags
// Purpose: buffers incoming spike source addresses in arrival order.
// Ports:
//   CLK, RST_N  clock and asynchronous active-low reset
//   clear       flush all entries (dominates push/pop)
//   push, din   write one entry when not full
//   pop         drop the head entry when not empty
//   dout        head entry, valid whenever empty is low
//   full, empty occupancy flags
module spike_addr_fifo
   import spike_packet_receiver_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = ADDR_W
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   // Head word lives in the register array, so it is presented with no read latency.
   assign dout    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/spike_packet_receiver.sv
// rtl/spike_packet_receiver.sv - maps incoming spike packets to per-neuron weight outputs
// Purpose: buffers spike source addresses, then scans the connection table one
//          slot per cycle and emits {neuron, weight} for every matching slot.
// Ports:
//   CLK, RST_N                     clock and asynchronous active-low reset
//   clear                          timestep flush of FIFO, scan and output
//   pkt_valid, pkt_addr, pkt_ready incoming spike packet handshake
//   cfg_we, cfg_idx, cfg_src,
//   cfg_weight, cfg_en, cfg_err    connection table write port and reject pulse
//   wout_valid, wout_neuron,
//   wout_weight, wout_ready        registered weight output handshake
//   busy                           packet pending or scan in progress
module spike_packet_receiver
   import spike_packet_receiver_pkg::*;
#(
   parameter int NUM_NEURONS     = DEF_NUM_NEURONS,
   parameter int CONN_PER_NEURON = DEF_CONN_PER_NEURON,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  clear,
   input  logic                  pkt_valid,
   input  logic [ADDR_W-1:0]     pkt_addr,
   output logic                  pkt_ready,
   input  logic                  cfg_we,
   input  logic [SLOT_IDX_W-1:0] cfg_idx,
   input  logic [ADDR_W-1:0]     cfg_src,
   input  logic [WEIGHT_W-1:0]   cfg_weight,
   input  logic                  cfg_en,
   output logic                  cfg_err,
   output logic                  wout_valid,
   output logic [NEURON_W-1:0]   wout_neuron,
   output logic [WEIGHT_W-1:0]   wout_weight,
   input  logic                  wout_ready,
   output logic                  busy
);

   localparam int NUM_SLOTS = NUM_NEURONS * CONN_PER_NEURON;
   localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

   logic [0:0]            state;
   logic [SLOT_IDX_W-1:0] slot;
   logic [ADDR_W-1:0]     scan_addr;

   logic [ADDR_W-1:0]     fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;

   logic                  slot_en     [NUM_SLOTS];
   logic [ADDR_W-1:0]     slot_src    [NUM_SLOTS];
   logic [WEIGHT_W-1:0]   slot_weight [NUM_SLOTS];

   logic                  out_free;
   logic                  hit;
   logic [NEURON_W-1:0]   hit_neuron;
   logic                  cfg_ok;

   assign pkt_ready  = !fifo_full;
   assign fifo_push  = pkt_valid && !fifo_full;
   assign fifo_pop   = (state == ST_IDLE) && !fifo_empty && !clear;
   assign busy       = !fifo_empty || (state != ST_IDLE);

   // The scan only advances when the output register is empty or being taken,
   // which makes the slot counter hold during back-pressure.
   assign out_free   = !wout_valid || wout_ready;
   assign hit        = slot_en[slot] && (slot_src[slot] == scan_addr);
   assign hit_neuron = NEURON_W'(32'(slot) / CONN_PER_NEURON);

   assign cfg_ok     = cfg_we && !busy && (32'(cfg_idx) < NUM_SLOTS);

   spike_addr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W)
   ) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clear (clear),
      .push  (fifo_push),
      .din   (pkt_addr),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= ST_IDLE;
         slot        <= '0;
         scan_addr   <= '0;
         wout_valid  <= 1'b0;
         wout_neuron <= '0;
         wout_weight <= '0;
      end else if (clear) begin
         state      <= ST_IDLE;
         slot       <= '0;
         wout_valid <= 1'b0;
      end else if (state == ST_IDLE) begin
         // A match from the final slot may still be waiting here.
         if (wout_ready) wout_valid <= 1'b0;
         if (!fifo_empty) begin
            scan_addr <= fifo_dout;
            slot      <= '0;
            state     <= ST_SCAN;
         end
      end else begin
         if (out_free) begin
            wout_valid <= hit;
            if (hit) begin
               wout_neuron <= hit_neuron;
               wout_weight <= slot_weight[slot];
            end
            if (slot == LAST_SLOT) begin
               slot  <= '0;
               state <= ST_IDLE;
            end else begin
               slot <= slot + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_SLOTS; i++) slot_en[i] <= 1'b0;
      end else if (cfg_ok) begin
         slot_en[cfg_idx] <= cfg_en;
      end
   end

   // Source and weight are meaningless while the valid bit is clear, so they skip reset.
   always_ff @(posedge CLK) begin
      if (cfg_ok) begin
         slot_src[cfg_idx]    <= cfg_src;
         slot_weight[cfg_idx] <= cfg_weight;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) cfg_err <= 1'b0;
      else        cfg_err <= cfg_we && !cfg_ok;
   end

endmodule

// File: tb/tb_spike_packet_receiver.sv
// tb/tb_spike_packet_receiver.sv - directed self-checking bench for spike_packet_receiver
module tb_spike_packet_receiver;

   localparam logic [31:0] W_A = 32'h3F80_0000;
   localparam logic [31:0] W_B = 32'h4000_0000;
   localparam logic [31:0] W_C = 32'h4040_0000;
   localparam logic [31:0] W_D = 32'h1111_1111;
   localparam logic [31:0] W_E = 32'h2222_2222;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        clear = 1'b0;
   logic        pkt_valid = 1'b0;
   logic [11:0] pkt_addr = '0;
   logic        pkt_ready;
   logic        cfg_we = 1'b0;
   logic [4:0]  cfg_idx = '0;
   logic [11:0] cfg_src = '0;
   logic [31:0] cfg_weight = '0;
   logic        cfg_en = 1'b0;
   logic        cfg_err;
   logic        wout_valid;
   logic [3:0]  wout_neuron;
   logic [31:0] wout_weight;
   logic        wout_ready = 1'b1;
   logic        busy;

   int checks = 0;
   int failures = 0;

   logic [31:0] got_w [$];
   logic [3:0]  got_n [$];
   logic [11:0] order [9];

   spike_packet_receiver dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .clear       (clear),
      .pkt_valid   (pkt_valid),
      .pkt_addr    (pkt_addr),
      .pkt_ready   (pkt_ready),
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_src     (cfg_src),
      .cfg_weight  (cfg_weight),
      .cfg_en      (cfg_en),
      .cfg_err     (cfg_err),
      .wout_valid  (wout_valid),
      .wout_neuron (wout_neuron),
      .wout_weight (wout_weight),
      .wout_ready  (wout_ready),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic cfg_write(input logic [4:0] idx, input logic [11:0] src,
                            input logic [31:0] w, input logic en);
      cfg_we     = 1'b1;
      cfg_idx    = idx;
      cfg_src    = src;
      cfg_weight = w;
      cfg_en     = en;
      tick();
      cfg_we     = 1'b0;
   endtask

   task automatic send(input logic [11:0] a);
      pkt_addr  = a;
      pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
   endtask

   // Runs until the receiver is idle with nothing pending, collecting accepted outputs.
   task automatic drain(output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
         if (wout_valid && wout_ready) begin
            got_w.push_back(wout_weight);
            got_n.push_back(wout_neuron);
         end
      end while ((busy || wout_valid) && cycles < 1000);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!wout_valid && n < 100) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int cyc;
      int acc;
      int n;

      order[0] = 12'd108; order[1] = 12'd100; order[2] = 12'd107;
      order[3] = 12'd101; order[4] = 12'd106; order[5] = 12'd102;
      order[6] = 12'd105; order[7] = 12'd103; order[8] = 12'd104;

      // Reset values while RST_N is held low
      #12;
      check("rst_pkt_ready",   32'(pkt_ready),   32'd1);
      check("rst_wout_valid",  32'(wout_valid),  32'd0);
      check("rst_wout_neuron", 32'(wout_neuron), 32'd0);
      check("rst_wout_weight", wout_weight,      32'd0);
      check("rst_cfg_err",     32'(cfg_err),     32'd0);
      check("rst_busy",        32'(busy),        32'd0);
      RST_N = 1'b1;
      tick();

      // Single match: pkt 5 hits slot 1 only; 1 pop cycle + 30 scan cycles
      cfg_write(5'd0, 12'd3, W_A, 1'b1);
      cfg_write(5'd1, 12'd5, W_B, 1'b1);
      cfg_write(5'd2, 12'd7, W_C, 1'b1);
      check("cfg_ok_no_err", 32'(cfg_err), 32'd0);
      got_w.delete(); got_n.delete();
      send(12'd5);
      check("t1_busy_after_push", 32'(busy), 32'd1);
      drain(cyc);
      check("t1_cycles_to_idle", 32'(cyc), 32'd31);
      check("t1_out_count", 32'(got_w.size()), 32'd1);
      check("t1_neuron", 32'(got_n[0]), 32'd0);
      check("t1_weight", got_w[0], W_B);

      // Two matching slots with a 5-cycle stall on the first
      cfg_write(5'd3,  12'd4, W_D, 1'b1);
      cfg_write(5'd13, 12'd4, W_E, 1'b1);
      wout_ready = 1'b0;
      send(12'd4);
      wait_valid();
      check("t2_first_valid",  32'(wout_valid),  32'd1);
      check("t2_first_neuron", 32'(wout_neuron), 32'd1);
      check("t2_first_weight", wout_weight,      W_D);
      repeat (5) tick();
      check("t2_hold_valid",  32'(wout_valid),  32'd1);
      check("t2_hold_neuron", 32'(wout_neuron), 32'd1);
      check("t2_hold_weight", wout_weight,      W_D);
      wout_ready = 1'b1;
      tick();
      check("t2_released", 32'(wout_valid), 32'd0);
      wait_valid();
      check("t2_second_valid",  32'(wout_valid),  32'd1);
      check("t2_second_neuron", 32'(wout_neuron), 32'd4);
      check("t2_second_weight", wout_weight,      W_E);
      got_w.delete(); got_n.delete();
      drain(cyc);
      check("t2_no_extra", 32'(got_w.size()), 32'd0);

      // Rejected configuration writes: while busy, and out-of-range index
      send(12'd9);
      cfg_we = 1'b1; cfg_idx = 5'd0; cfg_src = 12'd9; cfg_weight = 32'hDEAD_BEEF; cfg_en = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("t3_busy_err", 32'(cfg_err), 32'd1);
      tick();
      check("t3_busy_err_pulse", 32'(cfg_err), 32'd0);
      drain(cyc);
      cfg_we = 1'b1; cfg_idx = 5'd31; cfg_src = 12'd9; cfg_weight = 32'hDEAD_BEEF; cfg_en = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("t3_idx_err", 32'(cfg_err), 32'd1);
      tick();
      check("t3_idx_err_pulse", 32'(cfg_err), 32'd0);
      got_w.delete(); got_n.delete();
      send(12'd9);
      drain(cyc);
      check("t3_pkt9_no_match", 32'(got_w.size()), 32'd0);
      got_w.delete(); got_n.delete();
      send(12'd3);
      drain(cyc);
      check("t3_slot0_count", 32'(got_w.size()), 32'd1);
      check("t3_slot0_weight", got_w[0], W_A);

      // Nine back-to-back packets under back-pressure: 8 buffered + 1 in scan
      for (int k = 0; k < 9; k++)
         cfg_write(5'(16 + k), 12'(100 + k), 32'hA000_0000 + 32'(k), 1'b1);
      wout_ready = 1'b0;
      acc = 0;
      for (int k = 0; k < 9; k++) begin
         pkt_addr  = order[k];
         pkt_valid = 1'b1;
         if (pkt_ready) acc++;
         tick();
      end
      pkt_valid = 1'b0;
      check("t4_accepted", 32'(acc), 32'd9);
      check("t4_full_ready", 32'(pkt_ready), 32'd0);
      got_w.delete(); got_n.delete();
      wout_ready = 1'b1;
      drain(cyc);
      check("t4_out_count", 32'(got_w.size()), 32'd9);
      for (int k = 0; k < 9; k++)
         check("t4_order", got_w[k], 32'hA000_0000 + 32'(order[k] - 12'd100));
      check("t4_ready_after", 32'(pkt_ready), 32'd1);

      // Clear mid-scan with three packets queued and a packet offered that cycle
      wout_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(12'd4);
      wait_valid();
      check("t5_valid_before_clear", 32'(wout_valid), 32'd1);
      clear = 1'b1; pkt_valid = 1'b1; pkt_addr = 12'd4;
      tick();
      clear = 1'b0; pkt_valid = 1'b0;
      check("t5_valid_after_clear", 32'(wout_valid), 32'd0);
      check("t5_busy_after_clear",  32'(busy),       32'd0);
      check("t5_ready_after_clear", 32'(pkt_ready),  32'd1);
      wout_ready = 1'b1;
      n = 0;
      repeat (100) begin
         tick();
         if (wout_valid) n++;
      end
      check("t5_no_outputs", 32'(n), 32'd0);

      // Asynchronous reset mid-scan, between clock edges
      wout_ready = 1'b0;
      send(12'd4);
      wait_valid();
      check("t6_valid_before_rst", 32'(wout_valid), 32'd1);
      #2 RST_N = 1'b0;
      #1;
      check("t6_rst_valid",  32'(wout_valid),  32'd0);
      check("t6_rst_neuron", 32'(wout_neuron), 32'd0);
      check("t6_rst_weight", wout_weight,      32'd0);
      check("t6_rst_busy",   32'(busy),        32'd0);
      check("t6_rst_cfg_err", 32'(cfg_err),    32'd0);
      RST_N = 1'b1;
      tick();
      check("t6_ready_after_rst", 32'(pkt_ready), 32'd1);
      wout_ready = 1'b1;
      got_w.delete(); got_n.delete();
      send(12'd4);
      drain(cyc);
      check("t6_table_cleared", 32'(got_w.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
